// File: rtl/fetch_redirect_if.sv
// Fetch-redirect bundle: execute-stage redirect request in, fetch address and pipeline control out.
// DbgState mirrors the internal FSM state (BOOT=0, RUN=1, HOLD=2, FLUSH=3) so checkers can bind to it.
interface fetch_redirect_if;
    logic        Stall;
    logic        Diverge;
    logic        ExValid;
    logic [31:0] Target;
    logic [31:0] PC;
    logic        FetchValid;
    logic        Flush;
    logic [15:0] RedirectCount;
    logic [1:0]  DbgState;

    // Inputs are level signals sampled on every rising clk edge; there is no
    // valid/ready handshake, and Stall alone back-pressures the fetch address.
    modport master (
        output Stall, Diverge, ExValid, Target,
        input  PC, FetchValid, Flush, RedirectCount, DbgState
    );

    modport slave (
        input  Stall, Diverge, ExValid, Target,
        output PC, FetchValid, Flush, RedirectCount, DbgState
    );
endinterface

// File: rtl/fetch_redirect.sv
// Fetch PC sequencer: sequential fetch, taken-branch redirect with a one-cycle flush,
// and a redirect held over a stall until memory is ready again.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic            clk,
    input  logic            rst,
    fetch_redirect_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        fv_q, fv_d;
    logic        flush_q, flush_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    logic        taken;
    logic        enter_flush;
    logic [31:0] tgt_aligned;
    logic [31:0] pc_inc;

    assign taken       = bus.Diverge & bus.ExValid;
    assign tgt_aligned = {bus.Target[31:2], 2'b00};
    assign pc_inc      = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        fv_d        = fv_q;
        enter_flush = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                fv_d    = ~bus.Stall;
                if (!bus.Stall) pc_d = pc_inc;
            end
            RUN: begin
                if (!bus.Stall) begin
                    if (taken) begin
                        pc_d        = tgt_aligned;
                        state_d     = FLUSH;
                        fv_d        = 1'b0;
                        enter_flush = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                        fv_d = 1'b1;
                    end
                end else if (taken) begin
                    pend_d  = tgt_aligned;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // First latched target wins; later Diverge/Target are ignored here.
                if (!bus.Stall) begin
                    pc_d        = pend_q;
                    state_d     = FLUSH;
                    fv_d        = 1'b0;
                    enter_flush = 1'b1;
                end
            end
            FLUSH: begin
                // The cycle after FLUSH still returns a wrong-path word, hence fv stays low.
                fv_d = 1'b0;
                if (!bus.Stall) begin
                    pc_d    = pc_inc;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        flush_d = (state_d == FLUSH);

        redirect_cnt_d = redirect_cnt_q;
        if (enter_flush && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            pend_q         <= 32'd0;
            fv_q           <= 1'b0;
            flush_q        <= 1'b0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_q         <= pend_d;
            fv_q           <= fv_d;
            flush_q        <= flush_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.PC            = pc_q;
    assign bus.FetchValid    = fv_q;
    assign bus.Flush         = flush_q;
    assign bus.RedirectCount = redirect_cnt_q;
    assign bus.DbgState      = state_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: boot sequence, redirects, stalled redirects,
// PC wrap, reset during HOLD and counter saturation.
module tb_fetch_redirect;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] S_BOOT  = 32'd0;
    localparam logic [31:0] S_RUN   = 32'd1;
    localparam logic [31:0] S_HOLD  = 32'd2;
    localparam logic [31:0] S_FLUSH = 32'd3;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    fetch_redirect_if bus ();

    fetch_redirect #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic div, input logic exv, input logic [31:0] tgt);
        bus.Stall   = stall;
        bus.Diverge = div;
        bus.ExValid = exv;
        bus.Target  = tgt;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic fv,
                              input logic fl, input logic [31:0] cnt);
        check({tag, ".pc"}, bus.PC, pc);
        check({tag, ".fv"}, {31'd0, bus.FetchValid}, {31'd0, fv});
        check({tag, ".flush"}, {31'd0, bus.Flush}, {31'd0, fl});
        check({tag, ".cnt"}, {16'd0, bus.RedirectCount}, cnt);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        expect_out("reset", RST_PC, 1'b0, 1'b0, 32'd0);
        check("reset.state", {30'd0, bus.DbgState}, S_BOOT);

        // Free-run from boot.
        rst = 1'b0;
        tick();
        expect_out("boot1", 32'h4000_0004, 1'b1, 1'b0, 32'd0);
        check("boot1.state", {30'd0, bus.DbgState}, S_RUN);
        tick();
        check("seq08", bus.PC, 32'h4000_0008);
        tick();
        tick();
        check("seq10", bus.PC, 32'h4000_0010);

        // Redirect with unaligned target; Diverge held high through FLUSH is ignored.
        drive(1'b0, 1'b1, 1'b1, 32'h4000_0103);
        tick();
        expect_out("redir", 32'h4000_0100, 1'b0, 1'b1, 32'd1);
        drive(1'b0, 1'b1, 1'b1, 32'h4000_0500);
        tick();
        expect_out("post_flush", 32'h4000_0104, 1'b0, 1'b0, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("resume", 32'h4000_0108, 1'b1, 1'b0, 32'd1);

        // Diverge without ExValid is not a redirect.
        drive(1'b0, 1'b1, 1'b0, 32'h4000_0800);
        tick();
        expect_out("no_exvalid", 32'h4000_010C, 1'b1, 1'b0, 32'd1);

        // Stalled redirect: first target wins, PC frozen three cycles.
        drive(1'b1, 1'b1, 1'b1, 32'h4000_0200);
        tick();
        check("hold1.pc", bus.PC, 32'h4000_010C);
        check("hold1.state", {30'd0, bus.DbgState}, S_HOLD);
        drive(1'b1, 1'b1, 1'b1, 32'h4000_0300);
        tick();
        check("hold2.pc", bus.PC, 32'h4000_010C);
        drive(1'b1, 1'b0, 1'b0, 32'h4000_0300);
        tick();
        expect_out("hold3", 32'h4000_010C, 1'b1, 1'b0, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("hold_rel", 32'h4000_0200, 1'b0, 1'b1, 32'd2);
        tick();
        expect_out("hold_after", 32'h4000_0204, 1'b0, 1'b0, 32'd2);

        // RUN stall without redirect keeps PC and FetchValid.
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("stall_fv0", 32'h4000_0204, 1'b0, 1'b0, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("unstall", 32'h4000_0208, 1'b1, 1'b0, 32'd2);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("stall_fv1", 32'h4000_0208, 1'b1, 1'b0, 32'd2);

        // Wrap-around through a redirect to the top word.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        tick();
        expect_out("wrap_redir", 32'hFFFF_FFFC, 1'b0, 1'b1, 32'd3);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        check("wrap0", bus.PC, 32'h0000_0000);
        tick();
        expect_out("wrap4", 32'h0000_0004, 1'b1, 1'b0, 32'd3);

        // Stall during FLUSH keeps Flush asserted and PC held.
        drive(1'b0, 1'b1, 1'b1, 32'h4000_0040);
        tick();
        expect_out("fl_enter", 32'h4000_0040, 1'b0, 1'b1, 32'd4);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("fl_stall", 32'h4000_0040, 1'b0, 1'b1, 32'd4);
        check("fl_stall.state", {30'd0, bus.DbgState}, S_FLUSH);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("fl_exit", 32'h4000_0044, 1'b0, 1'b0, 32'd4);

        // Reset during HOLD discards the pending target even with Stall released.
        drive(1'b1, 1'b1, 1'b1, 32'h4000_0600);
        tick();
        check("rst_hold.state", {30'd0, bus.DbgState}, S_HOLD);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 32'h4000_0700);
        tick();
        expect_out("rst_in_hold", RST_PC, 1'b0, 1'b0, 32'd0);
        check("rst_in_hold.state", {30'd0, bus.DbgState}, S_BOOT);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        expect_out("rst_boot1", 32'h4000_0004, 1'b1, 1'b0, 32'd0);
        tick();
        expect_out("rst_boot2", 32'h4000_0008, 1'b1, 1'b0, 32'd0);

        // Counter increments once per redirect.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h4000_1000);
            tick();
            check("cnt_inc", {16'd0, bus.RedirectCount}, 32'(i + 1));
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            tick();
        end

        // Preload near the top so saturation is reached in a few cycles.
        dut.redirect_cnt_q = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h4000_2000);
            tick();
            check("cnt_sat", {16'd0, bus.RedirectCount}, (i == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            tick();
        end
        check("cnt_final", {16'd0, bus.RedirectCount}, 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
